// File: rtl/mor1kx_wb_arb_pkg.sv
// mor1kx_wb_arb_pkg: shared definitions for the 2:1 Wishbone B3 arbiter.
//   gnt_state_e : grant FSM encoding (NONE / GNT_I / GNT_D)
//   owner_e     : owner id of the last granted master (I / D)
//   CTI_*       : Wishbone B3 cycle type identifiers used on the bus
package mor1kx_wb_arb_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } gnt_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/mor1kx_wb_arb_timeout.sv
// mor1kx_wb_arb_timeout: stall counter with a one-cycle expiry flag.
// Only instantiated when MOR1KX_WB_ARB_TIMEOUT_EN is defined.
//   clk, rst  : clock, synchronous active-high reset
//   cnt_en    : owner strobes with no termination this cycle
//   clr       : clear request (termination, release or no owner)
//   expire_c  : counter has reached TIMEOUT_CYCLES (combinational)
module mor1kx_wb_arb_timeout
  import mor1kx_wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic cnt_en,
  input  logic clr,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  assign expire_c = (cnt_q == CW'(TIMEOUT_CYCLES));

  // Expiry clears the count itself so the pulse lasts exactly one cycle
  always_ff @(posedge clk) begin
    if (rst || clr || expire_c) begin
      cnt_q <= '0;
    end else if (cnt_en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mor1kx_wb_arb_2to1.sv
// mor1kx_wb_arb_2to1: round-robin 2:1 Wishbone B3 master arbiter.
// Merges the instruction (iwbm_*) and data (dwbm_*) master ports onto one
// shared master port (wbm_*). Grant is held for the whole cyc of the owner,
// bursts included; terminations go only to the owner; read data is broadcast.
// Optional feature: define MOR1KX_WB_ARB_TIMEOUT_EN to synthesise an err
// after TIMEOUT_CYCLES stalled strobe cycles.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   iwbm_*_i / iwbm_*_o  : instruction master request / response
//   dwbm_*_i / dwbm_*_o  : data master request / response
//   wbm_*_o / wbm_*_i    : shared bus request / response
module mor1kx_wb_arb_2to1
  import mor1kx_wb_arb_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  // instruction master
  input  logic [AW-1:0]     iwbm_adr_i,
  input  logic [DW-1:0]     iwbm_dat_i,
  input  logic              iwbm_stb_i,
  input  logic              iwbm_cyc_i,
  input  logic              iwbm_we_i,
  input  logic [DW/8-1:0]   iwbm_sel_i,
  input  logic [2:0]        iwbm_cti_i,
  input  logic [1:0]        iwbm_bte_i,
  output logic              iwbm_ack_o,
  output logic              iwbm_err_o,
  output logic              iwbm_rty_o,
  output logic [DW-1:0]     iwbm_dat_o,
  // data master
  input  logic [AW-1:0]     dwbm_adr_i,
  input  logic [DW-1:0]     dwbm_dat_i,
  input  logic              dwbm_stb_i,
  input  logic              dwbm_cyc_i,
  input  logic              dwbm_we_i,
  input  logic [DW/8-1:0]   dwbm_sel_i,
  input  logic [2:0]        dwbm_cti_i,
  input  logic [1:0]        dwbm_bte_i,
  output logic              dwbm_ack_o,
  output logic              dwbm_err_o,
  output logic              dwbm_rty_o,
  output logic [DW-1:0]     dwbm_dat_o,
  // shared bus
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  output logic              wbm_stb_o,
  output logic              wbm_cyc_o,
  output logic              wbm_we_o,
  output logic [DW/8-1:0]   wbm_sel_o,
  output logic [2:0]        wbm_cti_o,
  output logic [1:0]        wbm_bte_o,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  input  logic              wbm_rty_i,
  input  logic [DW-1:0]     wbm_dat_i
);

  gnt_state_e state_q, state_d;
  owner_e     last_q, last_d;
  logic       own_i, own_d, granted;
  logic       owner_cyc, owner_stb;
  logic       expire_c;

  // Grant state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NONE;
      last_q  <= OWNER_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Reset masks the current owner so nothing is forwarded in the reset cycle
  assign own_i     = (state_q == GNT_I) && !rst;
  assign own_d     = (state_q == GNT_D) && !rst;
  assign granted   = own_i || own_d;
  assign owner_cyc = own_d ? dwbm_cyc_i : iwbm_cyc_i;
  assign owner_stb = own_d ? dwbm_stb_i : iwbm_stb_i;

`ifdef MOR1KX_WB_ARB_TIMEOUT_EN
  logic any_term;
  assign any_term = wbm_ack_i | wbm_err_i | wbm_rty_i;

  mor1kx_wb_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .cnt_en   (wbm_stb_o && !any_term),
    .clr      (!granted || any_term || !owner_cyc),
    .expire_c (expire_c)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign expire_c = 1'b0;
`endif

  // Next-state and bus muxing
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    wbm_adr_o  = iwbm_adr_i;
    wbm_dat_o  = iwbm_dat_i;
    wbm_we_o   = 1'b0;
    wbm_sel_o  = iwbm_sel_i;
    wbm_cti_o  = iwbm_cti_i;
    wbm_bte_o  = iwbm_bte_i;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    iwbm_ack_o = 1'b0;
    iwbm_err_o = 1'b0;
    iwbm_rty_o = 1'b0;
    dwbm_ack_o = 1'b0;
    dwbm_err_o = 1'b0;
    dwbm_rty_o = 1'b0;
    iwbm_dat_o = '0;
    dwbm_dat_o = '0;

    case (state_q)
      NONE: begin
        // A tie goes to whichever master did not own the bus last
        if (iwbm_cyc_i && dwbm_cyc_i) begin
          state_d = (last_q == OWNER_I) ? GNT_D : GNT_I;
        end else if (dwbm_cyc_i) begin
          state_d = GNT_D;
        end else if (iwbm_cyc_i) begin
          state_d = GNT_I;
        end
      end
      GNT_I: begin
        if (!iwbm_cyc_i) begin
          state_d = NONE;
          last_d  = OWNER_I;
        end
      end
      GNT_D: begin
        if (!dwbm_cyc_i) begin
          state_d = NONE;
          last_d  = OWNER_D;
        end
      end
      default: state_d = NONE;
    endcase

    if (own_d) begin
      wbm_adr_o = dwbm_adr_i;
      wbm_dat_o = dwbm_dat_i;
      wbm_sel_o = dwbm_sel_i;
      wbm_cti_o = dwbm_cti_i;
      wbm_bte_o = dwbm_bte_i;
    end

    if (granted) begin
      wbm_we_o   = own_d ? dwbm_we_i : iwbm_we_i;
      wbm_cyc_o  = owner_cyc && !expire_c;
      wbm_stb_o  = owner_stb && !expire_c;
      iwbm_dat_o = wbm_dat_i;
      dwbm_dat_o = wbm_dat_i;
    end

    // Expiry turns into an err for the owner and hides a late ack/rty
    if (own_i) begin
      iwbm_ack_o = wbm_ack_i && !expire_c;
      iwbm_err_o = wbm_err_i || expire_c;
      iwbm_rty_o = wbm_rty_i && !expire_c;
    end
    if (own_d) begin
      dwbm_ack_o = wbm_ack_i && !expire_c;
      dwbm_err_o = wbm_err_i || expire_c;
      dwbm_rty_o = wbm_rty_i && !expire_c;
    end
  end

endmodule

// File: tb/tb_mor1kx_wb_arb_2to1.sv
// Self-checking bench for mor1kx_wb_arb_2to1: directed vector table,
// hand-written burst/reset/timeout sequences and a randomized run checked
// against a transaction-level arbitration model.
module tb_mor1kx_wb_arb_2to1;
  import mor1kx_wb_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 4;
  localparam logic [31:0] I_ADR = 32'h0000_0100;
  localparam logic [31:0] D_ADR = 32'h0000_0200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] i_adr, d_adr, m_adr;
  logic [DW-1:0] i_dat, d_dat, m_dat, s_dat, idat, ddat;
  logic          i_stb, i_cyc, i_we, d_stb, d_cyc, d_we;
  logic [SW-1:0] i_sel, d_sel, m_sel;
  logic [2:0]    i_cti, d_cti, m_cti;
  logic [1:0]    i_bte, d_bte, m_bte;
  logic          iack, ierr, irty, dack, derr, drty;
  logic          m_stb, m_cyc, m_we;
  logic          s_ack, s_err, s_rty;

  mor1kx_wb_arb_2to1 #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .iwbm_adr_i(i_adr), .iwbm_dat_i(i_dat), .iwbm_stb_i(i_stb), .iwbm_cyc_i(i_cyc),
    .iwbm_we_i(i_we), .iwbm_sel_i(i_sel), .iwbm_cti_i(i_cti), .iwbm_bte_i(i_bte),
    .iwbm_ack_o(iack), .iwbm_err_o(ierr), .iwbm_rty_o(irty), .iwbm_dat_o(idat),
    .dwbm_adr_i(d_adr), .dwbm_dat_i(d_dat), .dwbm_stb_i(d_stb), .dwbm_cyc_i(d_cyc),
    .dwbm_we_i(d_we), .dwbm_sel_i(d_sel), .dwbm_cti_i(d_cti), .dwbm_bte_i(d_bte),
    .dwbm_ack_o(dack), .dwbm_err_o(derr), .dwbm_rty_o(drty), .dwbm_dat_o(ddat),
    .wbm_adr_o(m_adr), .wbm_dat_o(m_dat), .wbm_stb_o(m_stb), .wbm_cyc_o(m_cyc),
    .wbm_we_o(m_we), .wbm_sel_o(m_sel), .wbm_cti_o(m_cti), .wbm_bte_o(m_bte),
    .wbm_ack_i(s_ack), .wbm_err_i(s_err), .wbm_rty_i(s_rty), .wbm_dat_i(s_dat)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read 3 later
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_adr = I_ADR; i_dat = 32'h1111_1111; i_stb = 0; i_cyc = 0; i_we = 0;
    i_sel = 4'hF; i_cti = CTI_CLASSIC; i_bte = 2'b00;
    d_adr = D_ADR; d_dat = 32'h2222_2222; d_stb = 0; d_cyc = 0; d_we = 0;
    d_sel = 4'h3; d_cti = CTI_CLASSIC; d_bte = 2'b00;
    s_ack = 0; s_err = 0; s_rty = 0; s_dat = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, ic, dc, ack, err;
    logic [31:0] sdat;
    logic        e_cyc;
    int          e_own;      // 0 none, 1 I, 2 D
    logic        e_iack, e_dack, e_ierr, e_derr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, ic, dc, ack, err, input logic [31:0] sd,
                     input logic ec, input int own, input logic ia, da, ie, de);
    vec_t v;
    v.rst = r; v.ic = ic; v.dc = dc; v.ack = ack; v.err = err; v.sdat = sd;
    v.e_cyc = ec; v.e_own = own; v.e_iack = ia; v.e_dack = da; v.e_ierr = ie; v.e_derr = de;
    tbl.push_back(v);
  endtask

  // ---------------- reference model state ----------------
  int m_own;   // -1 none, 0 I, 1 D
  int m_last;  // 0 I, 1 D
  int m_cnt;

  initial begin
    int iacks;
    int saw_err;
    int cyc_low;
    clear_inputs();
    rst = 1;
    next_cycle();

    // rst ic dc ack err sdat  | cyc own iack dack ierr derr
    add(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);
    // I-only classic read, ack two cycles after the request
    add(0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 32'hDEADBEEF,   1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,          0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);
    // err routed to I only
    add(0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h0,          1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 32'h0,          0, 1, 0, 0, 0, 0);
    // reset, simultaneous request: D first, then alternate D,I,D,I
    add(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 32'hCAFEF00D,   1, 2, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 32'h0,          0, 2, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 32'h0,          0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 32'h12345678,   1, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 32'h0,          0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 32'hA5A5A5A5,   1, 2, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 32'h0,          0, 2, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 32'h5A5A5A5A,   1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,          0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);

    foreach (tbl[k]) begin
      rst = tbl[k].rst;
      i_cyc = tbl[k].ic; i_stb = tbl[k].ic;
      d_cyc = tbl[k].dc; d_stb = tbl[k].dc;
      s_ack = tbl[k].ack; s_err = tbl[k].err; s_dat = tbl[k].sdat;
      #3;
      check($sformatf("vec%0d cyc", k), 64'(m_cyc), 64'(tbl[k].e_cyc));
      check($sformatf("vec%0d stb", k), 64'(m_stb), 64'(tbl[k].e_cyc));
      check($sformatf("vec%0d iack", k), 64'(iack), 64'(tbl[k].e_iack));
      check($sformatf("vec%0d dack", k), 64'(dack), 64'(tbl[k].e_dack));
      check($sformatf("vec%0d ierr", k), 64'(ierr), 64'(tbl[k].e_ierr));
      check($sformatf("vec%0d derr", k), 64'(derr), 64'(tbl[k].e_derr));
      check($sformatf("vec%0d idat", k), 64'(idat), (tbl[k].e_own != 0) ? 64'(tbl[k].sdat) : 64'h0);
      if (tbl[k].e_own == 1) check($sformatf("vec%0d adr", k), 64'(m_adr), 64'(I_ADR));
      if (tbl[k].e_own == 2) check($sformatf("vec%0d adr", k), 64'(m_adr), 64'(D_ADR));
      next_cycle();
    end

    // ---------------- I 8-beat burst, D requests at beat 2 ----------------
    do_reset();
    i_cyc = 1; i_stb = 1; i_cti = CTI_INCR; i_adr = 32'h1000;
    #3;
    check("burst arb cyc", 64'(m_cyc), 64'h0);
    next_cycle();
    iacks = 0;
    for (int b = 0; b < 8; b++) begin
      i_cti = (b == 7) ? CTI_EOB : CTI_INCR;
      i_adr = 32'h1000 + 32'(4 * b);
      d_cyc = (b >= 1); d_stb = (b >= 1);
      s_ack = 1; s_dat = 32'(b + 16);
      #3;
      if (iack) iacks++;
      check($sformatf("burst b%0d cyc", b), 64'(m_cyc), 64'h1);
      check($sformatf("burst b%0d adr", b), 64'(m_adr), 64'(32'h1000 + 32'(4 * b)));
      check($sformatf("burst b%0d cti", b), 64'(m_cti), (b == 7) ? 64'(CTI_EOB) : 64'(CTI_INCR));
      check($sformatf("burst b%0d dack", b), 64'(dack), 64'h0);
      check($sformatf("burst b%0d idat", b), 64'(idat), 64'(b + 16));
      next_cycle();
    end
    check("burst ack count", 64'(iacks), 64'd8);
    i_cyc = 0; i_stb = 0; s_ack = 0;
    #3;
    check("burst release cyc", 64'(m_cyc), 64'h0);
    next_cycle();
    #3;
    check("burst gap cyc", 64'(m_cyc), 64'h0);
    next_cycle();
    #3;
    check("burst D grant cyc", 64'(m_cyc), 64'h1);
    check("burst D grant adr", 64'(m_adr), 64'(D_ADR));
    next_cycle();

    // ---------------- reset during a D write ----------------
    do_reset();
    d_cyc = 1; d_stb = 1; d_we = 1;
    next_cycle();
    #3;
    check("rstwr cyc", 64'(m_cyc), 64'h1);
    check("rstwr we", 64'(m_we), 64'h1);
    next_cycle();
    rst = 1;
    next_cycle();
    rst = 0; s_ack = 1;
    #3;
    check("rstwr cyc after", 64'(m_cyc), 64'h0);
    check("rstwr dack dropped", 64'(dack), 64'h0);
    check("rstwr iack dropped", 64'(iack), 64'h0);
    next_cycle();

    // ---------------- stalled slave ----------------
    do_reset();
    d_cyc = 1; d_stb = 1;
`ifdef MOR1KX_WB_ARB_TIMEOUT_EN
    next_cycle();                        // stb rises in this cycle
    for (int c = 0; c < 4; c++) begin
      #3;
      check($sformatf("to stall%0d cyc", c), 64'(m_cyc), 64'h1);
      check($sformatf("to stall%0d derr", c), 64'(derr), 64'h0);
      next_cycle();
    end
    #3;
    check("to expire derr", 64'(derr), 64'h1);
    check("to expire cyc", 64'(m_cyc), 64'h0);
    check("to expire stb", 64'(m_stb), 64'h0);
    check("to expire ierr", 64'(ierr), 64'h0);
    next_cycle();
    d_cyc = 0; d_stb = 0;
    #3;
    check("to pulse width derr", 64'(derr), 64'h0);
    next_cycle();
`else
    saw_err = 0; cyc_low = 0;
    for (int c = 0; c < 1000; c++) begin
      next_cycle();
      #3;
      if (derr || ierr) saw_err++;
      if (!m_cyc) cyc_low++;
    end
    check("stall no err", 64'(saw_err), 64'h0);
    check("stall cyc held", 64'(cyc_low), 64'h0);
    next_cycle();
`endif

    // ---------------- randomized run against the model ----------------
    do_reset();
    m_own = -1; m_last = 0; m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      int   g;
      logic xp, e_cyc, e_stb;
      logic cyc_in[2], stb_in[2];
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) i_cyc = ~i_cyc;
      if ($urandom_range(0, 3) == 0) d_cyc = ~d_cyc;
      i_stb = i_cyc & 1'($urandom_range(0, 3) != 0);
      d_stb = d_cyc & 1'($urandom_range(0, 3) != 0);
      i_adr = $urandom; i_dat = $urandom; i_we = 1'($urandom); i_sel = 4'($urandom);
      i_cti = 3'($urandom); i_bte = 2'($urandom);
      d_adr = $urandom; d_dat = $urandom; d_we = 1'($urandom); d_sel = 4'($urandom);
      d_cti = 3'($urandom); d_bte = 2'($urandom);
      s_ack = ($urandom_range(0, 4) == 0);
      s_err = ($urandom_range(0, 15) == 0);
      s_rty = ($urandom_range(0, 15) == 0);
      s_dat = $urandom;
      #3;
      cyc_in[0] = i_cyc; cyc_in[1] = d_cyc;
      stb_in[0] = i_stb; stb_in[1] = d_stb;
      g = rst ? -1 : m_own;
`ifdef MOR1KX_WB_ARB_TIMEOUT_EN
      xp = (g >= 0) && (m_cnt == int'(TO));
`else
      xp = 1'b0;
`endif
      e_cyc = (g >= 0) && cyc_in[g] && !xp;
      e_stb = (g >= 0) && stb_in[g] && !xp;
      check("rnd cyc", 64'(m_cyc), 64'(e_cyc));
      check("rnd stb", 64'(m_stb), 64'(e_stb));
      check("rnd iterm", 64'({iack, ierr, irty}),
            (g == 0) ? 64'({s_ack && !xp, s_err || xp, s_rty && !xp}) : 64'h0);
      check("rnd dterm", 64'({dack, derr, drty}),
            (g == 1) ? 64'({s_ack && !xp, s_err || xp, s_rty && !xp}) : 64'h0);
      check("rnd idat", 64'(idat), (g >= 0) ? 64'(s_dat) : 64'h0);
      check("rnd ddat", 64'(ddat), (g >= 0) ? 64'(s_dat) : 64'h0);
      if (g >= 0) begin
        check("rnd adr", 64'(m_adr), (g == 1) ? 64'(d_adr) : 64'(i_adr));
        check("rnd wdat", 64'(m_dat), (g == 1) ? 64'(d_dat) : 64'(i_dat));
        check("rnd we", 64'(m_we), (g == 1) ? 64'(d_we) : 64'(i_we));
        check("rnd sel", 64'(m_sel), (g == 1) ? 64'(d_sel) : 64'(i_sel));
        check("rnd cti", 64'(m_cti), (g == 1) ? 64'(d_cti) : 64'(i_cti));
        check("rnd bte", 64'(m_bte), (g == 1) ? 64'(d_bte) : 64'(i_bte));
      end
      // advance the model at the clock edge
      if (rst) begin
        m_own = -1; m_last = 0; m_cnt = 0;
      end else if (m_own < 0) begin
        if (i_cyc && d_cyc) m_own = 1 - m_last;
        else if (d_cyc)     m_own = 1;
        else if (i_cyc)     m_own = 0;
        m_cnt = 0;
      end else if (!cyc_in[m_own]) begin
        m_last = m_own; m_own = -1; m_cnt = 0;
      end else if (xp || s_ack || s_err || s_rty) begin
        m_cnt = 0;
      end else if (e_stb) begin
        m_cnt++;
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mor1kx_wb_arb_2to1.md
Name: mor1kx_wb_arb_2to1

Overview:
- Downstream of the stand-alone MAROCCHINO top.
- Consumes the separate instruction-side (iwbm_*) and data-side (dwbm_*) Wishbone B3 master ports.
- Merges them onto one shared Wishbone master port for single-port SoC interconnects.
- Arbitration is round-robin. Grant is held for the whole cyc of the owning master, including B3 bursts.
- Terminations (ack/err/rty) are routed back only to the owning master.

Parameters:
- AW, 32, address width of all three ports.
- DW, 32, data width of all three ports (sel width is DW/8).
- TIMEOUT_CYCLES, 255, cycles without termination before a synthetic err (used only with the optional feature).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- iwbm_adr_i / iwbm_dat_i  in  AW / DW  instruction master address / write data.
- iwbm_stb_i / iwbm_cyc_i / iwbm_we_i  in  1 each  instruction master strobe / cycle / write enable.
- iwbm_sel_i  in  DW/8  instruction master byte select.
- iwbm_cti_i / iwbm_bte_i  in  3 / 2  instruction master cycle type / burst type.
- iwbm_ack_o / iwbm_err_o / iwbm_rty_o  out  1 each  instruction master terminations.
- iwbm_dat_o  out  DW  instruction master read data.
- dwbm_*  same set and widths as iwbm_*, data master.
- wbm_adr_o / wbm_dat_o  out  AW / DW  shared bus address / write data.
- wbm_stb_o / wbm_cyc_o / wbm_we_o  out  1 each  shared bus strobe / cycle / write enable.
- wbm_sel_o / wbm_cti_o / wbm_bte_o  out  DW/8 / 3 / 2  shared bus byte select / cycle type / burst type.
- wbm_ack_i / wbm_err_i / wbm_rty_i  in  1 each  shared bus terminations.
- wbm_dat_i  in  DW  shared bus read data.

Behaviour:
- Grant state is a registered FSM with states NONE, GNT_I and GNT_D.
- Reset values: state=NONE, last_owner=I. All outputs are 0 in reset and while in NONE. wbm_adr/dat/sel/cti/bte may show the I inputs in NONE, but cyc/stb stay 0.
- NONE:
  - dwbm_cyc_i only -> GNT_D.
  - iwbm_cyc_i only -> GNT_I.
  - Both -> the master other than last_owner. So after reset, a tie goes to D.
  - Arbitration costs 1 cycle: a request seen in NONE reaches wbm_cyc_o on the next cycle.
- GNT_x:
  - wbm_* outputs are combinationally muxed from master x.
  - wbm_cyc_o = x_cyc_i; wbm_stb_o = x_stb_i.
  - x_ack/err/rty_o = wbm_ack/err/rty_i. The non-owner's terminations are forced to 0.
  - wbm_dat_i is broadcast to both iwbm_dat_o and dwbm_dat_o.
- Release from GNT_x:
  - When x_cyc_i=0, the next state is NONE and last_owner<=x.
  - The waiting master is granted one cycle later. There is no back-to-back grant, so wbm_cyc_o has a ≥1-cycle gap between owners.
- No preemption: a burst (cti=001/010) runs to its last beat (cti=111) and cyc drop, regardless of the other request.
- The non-owner's stb/cyc are ignored. It sees no termination and simply waits.
- Terminations arriving in NONE are discarded and not forwarded to either master.
- Reset mid-transfer: state goes to NONE immediately, wbm_cyc_o=0 next cycle, and no termination is forwarded.

Optional Feature:
- Macro: MOR1KX_WB_ARB_TIMEOUT_EN.
- Enabled:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits increments each GNT_x cycle with wbm_stb_o=1 and no ack/err/rty.
  - It clears on any termination, on release and on reset.
  - On reaching TIMEOUT_CYCLES: x_err_o=1 for exactly one cycle, wbm_cyc_o/wbm_stb_o forced 0 in that cycle, counter cleared. The master is expected to drop cyc; normal release follows.
- Disabled: no counter logic; a stalled slave hangs the owner indefinitely.

Decomposition:
- Package mor1kx_wb_arb_pkg: grant state encoding (NONE=2'b00, GNT_I=2'b01, GNT_D=2'b10), the CTI constants CLASSIC=000, INCR=010 and EOB=111, and the owner id constants I/D.
- One sub-module, mor1kx_wb_arb_timeout: counter plus expiry pulse, instantiated only under MOR1KX_WB_ARB_TIMEOUT_EN.
- The FSM and muxes stay in the top.

Test Plan:
- I-only classic read:
  - Stimulus: iwbm_cyc/stb=1 adr=0x100 at cycle 0; slave acks at cycle 2 with dat=0xDEADBEEF.
  - Required: wbm_cyc_o=1 from cycle 1; iwbm_ack_o=1 and iwbm_dat_o=0xDEADBEEF at cycle 2; dwbm_ack_o stays 0.
- Simultaneous request after reset:
  - Stimulus: iwbm and dwbm assert cyc in the same cycle.
  - Required: D granted first (wbm_adr_o = D address). After D drops cyc, 1 idle cycle, then I granted.
- I 8-beat burst (cti 010×7 then 111) with D requesting at beat 2:
  - Required: all 8 acks go to I and the burst is unbroken; D is granted only after I drops cyc.
- Round-robin fairness:
  - Stimulus: both masters re-request continuously for 4 transactions.
  - Required: grant order D,I,D,I.
- Reset during a D write:
  - Stimulus: rst=1 while an ack is pending.
  - Required: wbm_cyc_o=0 on the next cycle; a wbm_ack_i arriving afterwards is not forwarded to either master.
- Timeout (MOR1KX_WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: D read with no slave ack.
  - Required: dwbm_err_o pulses 1 cycle, 4 stalled cycles after wbm_stb_o rose; wbm_cyc_o=0 in that cycle.
  - Without the macro, the bench sees no err after 1000 cycles.
